// File: rtl/vga_pic_sched.sv
// vga_pic_sched: pixel-source scheduler between vga_ctrl timing and a 1-cycle synchronous
// picture ROM. Looks one pixel ahead, issues the ROM read, then muxes the ROM word or an
// 8-bar colour background so pix_data_o lines up with the pixel shown in the same cycle.
// A PIC_W x PIC_H window bounces around the active area, moving only on vsync rising edges.
// Optional feature: define PIC_BORDER_EN to draw a BORDER_COLOR frame around the window.
module vga_pic_sched #(
  parameter int unsigned H_VALID      = 640,
  parameter int unsigned V_VALID      = 480,
  parameter int unsigned PIC_W        = 100,
  parameter int unsigned PIC_H        = 100,
  parameter int unsigned ROM_AW       = 14,
  parameter int unsigned STEP         = 1,
  parameter int unsigned FRAME_DIV    = 1,
  parameter logic [15:0] BORDER_COLOR = 16'hFFFF
) (
  input  logic              vga_clk_i,
  input  logic              sys_rst_i,
  input  logic [9:0]        pix_x_i,
  input  logic [9:0]        pix_y_i,
  input  logic              vsync_i,
  input  logic [15:0]       rom_q_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  output logic              rom_rd_en_o,
  output logic [15:0]       pix_data_o,
  output logic [9:0]        pic_x0_o,
  output logic [9:0]        pic_y0_o
);

  localparam int unsigned DivW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(FRAME_DIV - 1);

  localparam logic [9:0]  Blank  = 10'h3FF;
  localparam logic [9:0]  HValid = 10'(H_VALID);
  localparam logic [9:0]  VValid = 10'(V_VALID);
  localparam logic [9:0]  HLast  = 10'(H_VALID - 1);
  localparam logic [9:0]  BarW   = 10'(H_VALID / 8);
  localparam logic [9:0]  PicW1  = 10'(PIC_W - 1);
  localparam logic [9:0]  PicH1  = 10'(PIC_H - 1);
  localparam logic [9:0]  Step10 = 10'(STEP);
  localparam logic [10:0] Step11 = 11'(STEP);
  localparam logic [10:0] XMax   = 11'(H_VALID - PIC_W);
  localparam logic [10:0] YMax   = 11'(V_VALID - PIC_H);

  typedef enum logic {XRight, XLeft} x_dir_e;
  typedef enum logic {YDown, YUp} y_dir_e;

  logic            vsync_q;
  logic            vs_rise;
  logic            move;
  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      x0_q, x0_d;
  logic [9:0]      y0_q, y0_d;
  x_dir_e          xdir_q, xdir_d;
  y_dir_e          ydir_q, ydir_d;
  logic [9:0]      yline_q, yline_d;
  logic            sel_q, sel_d;
  logic [15:0]     bg_q, bg_d;

  logic [9:0]        nx, ny, dx, dy;
  logic [10:0]       x_end, y_end;
  logic              in_act, in_win, on_border;
  logic [ROM_AW-1:0] addr;
  logic [2:0]        bar_idx;
  logic [15:0]       bar_color;

  assign vs_rise = vsync_i & ~vsync_q;
  assign move    = vs_rise && (div_q == DivLast);

  // Lookahead coordinates: the pixel vga_ctrl will show next cycle.
  always_comb begin
    nx = pix_x_i + 10'd1;
    ny = (pix_x_i != Blank) ? pix_y_i : yline_q;
    dx = nx - x0_q;
    dy = ny - y0_q;
    x_end = {1'b0, x0_q} + 11'(PIC_W);
    y_end = {1'b0, y0_q} + 11'(PIC_H);
    in_act = (nx < HValid) && (ny < VValid);
    in_win = in_act && (nx >= x0_q) && ({1'b0, nx} < x_end)
                    && (ny >= y0_q) && ({1'b0, ny} < y_end);
    addr = ROM_AW'(dy) * ROM_AW'(PIC_W) + ROM_AW'(dx);
`ifdef PIC_BORDER_EN
    on_border = in_win && ((dx == 10'd0) || (dx == PicW1) || (dy == 10'd0) || (dy == PicH1));
`else
    on_border = 1'b0;
`endif
  end

  // Background bar colour for the lookahead column.
  always_comb begin
    bar_idx = 3'(nx / BarW);
    case (bar_idx)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'h0000;
      3'd2:    bar_color = 16'hF800;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'h001F;
      3'd5:    bar_color = 16'hFFE0;
      3'd6:    bar_color = 16'hF81F;
      default: bar_color = 16'h07FF;
    endcase
  end

  // ROM request and next-stage selection; read enable is forced low during reset.
  always_comb begin
    rom_addr_o  = in_win ? addr : '0;
    rom_rd_en_o = in_win & ~on_border & ~sys_rst_i;
    sel_d       = in_win & ~on_border;
    if (!in_act) begin
      bg_d = 16'h0000;
    end else if (on_border) begin
      bg_d = BORDER_COLOR;
    end else begin
      bg_d = bar_color;
    end
  end

  // Line tracker so the lookahead during horizontal blank knows the upcoming line.
  always_comb begin
    yline_d = yline_q;
    if (vs_rise) begin
      yline_d = 10'd0;
    end else if ((pix_x_i == HLast) && (pix_y_i != Blank)) begin
      yline_d = pix_y_i + 10'd1;
    end
  end

  // Frame divider: counts vsync rising edges, wraps at FRAME_DIV.
  always_comb begin
    div_d = div_q;
    if (vs_rise) begin
      div_d = (div_q == DivLast) ? '0 : div_q + DivW'(1);
    end
  end

  // Horizontal bounce FSM; position only updates on a move event.
  always_comb begin
    x0_d   = x0_q;
    xdir_d = xdir_q;
    if (move) begin
      unique case (xdir_q)
        XRight: begin
          if ({1'b0, x0_q} + Step11 >= XMax) begin
            x0_d   = XMax[9:0];
            xdir_d = XLeft;
          end else begin
            x0_d = x0_q + Step10;
          end
        end
        XLeft: begin
          if (x0_q <= Step10) begin
            x0_d   = 10'd0;
            xdir_d = XRight;
          end else begin
            x0_d = x0_q - Step10;
          end
        end
      endcase
    end
  end

  // Vertical bounce FSM; mirrors the horizontal one.
  always_comb begin
    y0_d   = y0_q;
    ydir_d = ydir_q;
    if (move) begin
      unique case (ydir_q)
        YDown: begin
          if ({1'b0, y0_q} + Step11 >= YMax) begin
            y0_d   = YMax[9:0];
            ydir_d = YUp;
          end else begin
            y0_d = y0_q + Step10;
          end
        end
        YUp: begin
          if (y0_q <= Step10) begin
            y0_d   = 10'd0;
            ydir_d = YDown;
          end else begin
            y0_d = y0_q - Step10;
          end
        end
      endcase
    end
  end

  // State registers and output stage.
  always_ff @(posedge vga_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      vsync_q <= 1'b0;
      div_q   <= '0;
      x0_q    <= 10'd0;
      y0_q    <= 10'd0;
      xdir_q  <= XRight;
      ydir_q  <= YDown;
      yline_q <= 10'd0;
      sel_q   <= 1'b0;
      bg_q    <= 16'h0000;
    end else begin
      vsync_q <= vsync_i;
      div_q   <= div_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      xdir_q  <= xdir_d;
      ydir_q  <= ydir_d;
      yline_q <= yline_d;
      sel_q   <= sel_d;
      bg_q    <= bg_d;
    end
  end

  // ROM word arrives one cycle after the lookahead request, matching the current pixel.
  assign pix_data_o = sel_q ? rom_q_i : bg_q;
  assign pic_x0_o   = x0_q;
  assign pic_y0_o   = y0_q;

endmodule

// File: tb/tb_vga_pic_sched.sv
// Testbench for vga_pic_sched: the bench plays vga_ctrl and the picture ROM, and checks every
// cycle against a frame-level reference (triangle-wave window position, bar/window rules).
module tb_vga_pic_sched;

  localparam int HV = 640;
  localparam int VV = 480;
  localparam int PW = 100;
  localparam int PH = 100;
  localparam int FD = 1;

  logic        clk;
  logic        rst;
  logic [9:0]  px, py;
  logic        vs;
  logic [15:0] rom_q;
  logic [13:0] rom_addr;
  logic        rd;
  logic [15:0] pix;
  logic [9:0]  x0o, y0o;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference-model state
  int yl_m     = 0;
  int rises_m  = 0;
  bit vs_prev  = 0;

  vga_pic_sched dut (
    .vga_clk_i  (clk),
    .sys_rst_i  (rst),
    .pix_x_i    (px),
    .pix_y_i    (py),
    .vsync_i    (vs),
    .rom_q_i    (rom_q),
    .rom_addr_o (rom_addr),
    .rom_rd_en_o(rd),
    .pix_data_o (pix),
    .pic_x0_o   (x0o),
    .pic_y0_o   (y0o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom_fn(int a);
    return 16'((a * 37 + 'h1357) & 'hFFFF);
  endfunction

  // Synchronous ROM model.
  always @(posedge clk) if (rd) rom_q <= rom_fn(int'(rom_addr));

  // Bounce position after n single-pixel moves is a triangle wave of period 2*span.
  function automatic int tri_pos(int n, int span);
    int p;
    p = n % (2 * span);
    return (p <= span) ? p : 2 * span - p;
  endfunction

  function automatic int wx0();
    return tri_pos(rises_m / FD, HV - PW);
  endfunction

  function automatic int wy0();
    return tri_pos(rises_m / FD, VV - PH);
  endfunction

  function automatic bit in_win(int x, int y);
    return x < HV && y < VV && x >= wx0() && x < wx0() + PW && y >= wy0() && y < wy0() + PH;
  endfunction

  function automatic bit on_bord(int x, int y);
`ifdef PIC_BORDER_EN
    return in_win(x, y) && (x == wx0() || x == wx0() + PW - 1 || y == wy0() ||
                            y == wy0() + PH - 1);
`else
    return (x < 0) && (y < 0);
`endif
  endfunction

  function automatic int waddr(int x, int y);
    return (y - wy0()) * PW + (x - wx0());
  endfunction

  function automatic logic [15:0] bar(int x);
    case (x / (HV / 8))
      0: return 16'hFFFF;
      1: return 16'h0000;
      2: return 16'hF800;
      3: return 16'h07E0;
      4: return 16'h001F;
      5: return 16'hFFE0;
      6: return 16'hF81F;
      default: return 16'h07FF;
    endcase
  endfunction

  function automatic logic [15:0] exp_pix(int x, int y);
    if (x >= HV || y >= VV) return 16'h0000;
    if (on_bord(x, y)) return 16'hFFFF;
    if (in_win(x, y)) return rom_fn(waddr(x, y));
    return bar(x);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // One pixel clock: drive inputs, check lookahead/ROM request, window and optionally pixel.
  task automatic step(int x, int y, bit v, bit chk_pix);
    int nx, ny;
    bit w;
    @(posedge clk);
    #1;
    px = 10'(x);
    py = 10'(y);
    vs = v;
    nx = (x + 1) & 1023;
    ny = (x != 1023) ? y : yl_m;
    w  = in_win(nx, ny);
    @(negedge clk);
    chk("rom_rd_en", 32'(rd), 32'(w && !on_bord(nx, ny)));
    chk("rom_addr", 32'(rom_addr), w ? 32'(waddr(nx, ny)) : 32'd0);
    chk("pic_x0", 32'(x0o), 32'(wx0()));
    chk("pic_y0", 32'(y0o), 32'(wy0()));
    if (chk_pix) chk("pix_data", 32'(pix), 32'(exp_pix(x, y)));
    if (v && !vs_prev) begin
      rises_m++;
      yl_m = 0;
    end else if (x == HV - 1 && y != 1023) begin
      yl_m = y + 1;
    end
    vs_prev = v;
  endtask

  task automatic vpulse();
    step(1023, 1023, 1'b1, 1'b0);
    step(1023, 1023, 1'b0, 1'b0);
  endtask

  // Run of consecutive pixels on line y, properly primed so the lookahead is valid.
  task automatic run(int y, int xs, int len);
    if (xs == 0) begin
      if (y > 0) step(HV - 1, y - 1, 1'b0, 1'b0);
      else vpulse();
      step(1023, 1023, 1'b0, 1'b0);
    end else begin
      step(xs - 1, y, 1'b0, 1'b0);
    end
    for (int i = 0; i < len; i++) step(xs + i, y, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_pix_data", 32'(pix), 32'd0);
    chk("rst_rd_en", 32'(rd), 32'd0);
    chk("rst_pic_x0", 32'(x0o), 32'd0);
    chk("rst_pic_y0", 32'(y0o), 32'd0);
    rises_m = 0;
    yl_m    = 0;
    vs_prev = 0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int y, xs, len, k;
    px = 10'h3FF;
    py = 10'h3FF;
    vs = 1'b0;
    rom_q = 16'h0;
    rst = 1'b0;
    #2;
    do_reset();

    // First pixel after reset: blank cycle requests addr 0, then (0,0) shows ROM word
    step(1023, 1023, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(i, 0, 1'b0, 1'b1);
    // Window at (0,0): lookahead (5,3) -> 305; (100,0) bar1
    run(3, 1, 10);
    run(0, 95, 10);
    // Outside window, bar 0 at bottom line, then blanking
    run(200, 75, 10);
    run(479, 0, 3);
    run(479, 630, 10);
    for (int i = 0; i < 3; i++) step(1023, 1023, 1'b0, 1'b1);

    // Bounce turn-around at the right edge
    do_reset();
    for (int i = 0; i < 540; i++) vpulse();
    chk("x0_after_540", 32'(x0o), 32'd540);
    vpulse();
    chk("x0_after_541", 32'(x0o), 32'd539);
    run(wy0() + 50, 530, 110);

    // Reset mid-line at (300,200), then resume
    run(200, 290, 11);
    do_reset();
    run(200, 301, 30);
    run(50, 0, 110);

    // Randomized window positions and pixel runs biased toward the window
    for (int it = 0; it < 30; it++) begin
      k = $urandom_range(0, 15);
      for (int j = 0; j < k; j++) vpulse();
      y = wy0() + $urandom_range(0, 110) - 5;
      if (y < 0) y = 0;
      if (y > VV - 1) y = VV - 1;
      xs = wx0() + $urandom_range(0, 110) - 10;
      if (xs < 1) xs = 1;
      if (xs > HV - 1) xs = HV - 1;
      len = $urandom_range(1, 40);
      if (xs + len > HV) len = HV - xs;
      run(y, xs, len);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
